// File: rtl/cia_timer_ctrl.sv
// rtl/cia_timer_ctrl.sv - CIA timer control register (CRA/CRB) storage and count gating
// Optional feature macro: CIA_TIMER_CNT_EN compiles in CNT pin edge detection and CNT gating.

package cia;
  typedef logic [7:0] reg8_t;

  typedef struct packed {
    logic start;
    logic toggle;
    logic count;
    logic force_load;
  } tctrl_t;
endpackage

module cia_timer_ctrl #(
  parameter int TIMER_B = 0
) (
  input  logic        clk,
  input  logic        res,
  input  logic        phi2_dn,
  input  logic        cr_w,
  input  cia::reg8_t  data,
  input  logic        cnt,
  input  logic        ufl_a,
  input  logic        ufl,
  output cia::tctrl_t ctrl,
  output logic        pbon,
  output cia::reg8_t  regs
);

  // Stored control register bits. Bit 4 (LOAD) is a strobe and is never stored.
  logic       start_q;
  logic       pbon_q;
  logic       outmode_q;
  logic       runmode_q;
  // Bits 7:5 kept together: INMODE (bit 5, or bits 6:5 on timer B) plus pass-through bits.
  logic [2:0] hi_q;

  // Registered strobes towards the timer.
  logic       count_q;
  logic       force_load_q;

  // Next-state values seen at this phi2_dn.
  logic       start_nx;
  logic [2:0] hi_nx;
  logic [1:0] inmode_nx;
  logic       cnt_rise;
  logic       cnt_lvl;
  logic       tick;

`ifdef CIA_TIMER_CNT_EN
  logic cnt_prev;

  // CNT history for rising-edge detection; reset high so a pin already high is not an edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_prev <= 1'b1;
    end else if (phi2_dn) begin
      cnt_prev <= cnt;
    end
  end

  assign cnt_rise = cnt & ~cnt_prev;
  assign cnt_lvl  = cnt;
`else
  // Without CNT support the pin is ignored and every CNT-based mode gives no tick.
  logic cnt_unused;
  assign cnt_unused = cnt;
  assign cnt_rise   = 1'b0;
  assign cnt_lvl    = 1'b0;
`endif

  // Register contents after this cycle: a write takes effect, otherwise stored bits hold.
  always_comb begin
    hi_nx     = cr_w ? data[7:5] : hi_q;
    inmode_nx = 2'b00;
    if (TIMER_B != 0) begin
      inmode_nx = hi_nx[1:0];
    end else begin
      inmode_nx = {1'b0, hi_nx[0]};
    end
  end

  // START priority: a write beats a one-shot underflow, which beats holding.
  always_comb begin
    start_nx = start_q;
    if (cr_w) begin
      start_nx = data[0];
    end else if (ufl && runmode_q) begin
      start_nx = 1'b0;
    end
  end

  // Count source select from the INMODE value that will be in force after this cycle,
  // so a write that changes INMODE does not produce one spurious tick from the old mode.
  always_comb begin
    tick = 1'b0;
    if (TIMER_B != 0) begin
      case (inmode_nx)
        2'b00:   tick = 1'b1;
        2'b01:   tick = cnt_rise;
        2'b10:   tick = ufl_a;
        default: tick = ufl_a & cnt_lvl;
      endcase
    end else begin
      tick = inmode_nx[0] ? cnt_rise : 1'b1;
    end
  end

  // Control register storage and registered timer strobes, all advanced on phi2_dn.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      start_q      <= 1'b0;
      pbon_q       <= 1'b0;
      outmode_q    <= 1'b0;
      runmode_q    <= 1'b0;
      hi_q         <= 3'b000;
      count_q      <= 1'b0;
      force_load_q <= 1'b0;
    end else if (phi2_dn) begin
      start_q <= start_nx;
      if (cr_w) begin
        pbon_q    <= data[1];
        outmode_q <= data[2];
        runmode_q <= data[3];
      end
      hi_q         <= hi_nx;
      force_load_q <= cr_w & data[4];
      count_q      <= start_nx & tick;
    end
  end

  assign ctrl.start      = start_q;
  assign ctrl.toggle     = outmode_q;
  assign ctrl.count      = count_q;
  assign ctrl.force_load = force_load_q;
  assign pbon            = pbon_q;
  assign regs            = {hi_q, 1'b0, runmode_q, outmode_q, pbon_q, start_q};

endmodule

// File: tb/tb_cia_timer_ctrl.sv
// tb/tb_cia_timer_ctrl.sv - scoreboard bench for cia_timer_ctrl (timer A and timer B decoding)

module tb_cia_timer_ctrl;

  localparam int CTRL_A = 0;
  localparam int REGS_A = 1;
  localparam int PBON_A = 2;
  localparam int CTRL_B = 3;
  localparam int REGS_B = 4;
  localparam int PBON_B = 5;

`ifdef CIA_TIMER_CNT_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        phi2_dn = 1'b1;
  logic        cnt = 1'b1;

  logic        a_cr_w = 1'b0;
  cia::reg8_t  a_data = 8'h00;
  logic        a_ufl = 1'b0;
  logic        a_ufl_a = 1'b0;
  cia::tctrl_t a_ctrl;
  logic        a_pbon;
  cia::reg8_t  a_regs;

  logic        b_cr_w = 1'b0;
  cia::reg8_t  b_data = 8'h00;
  logic        b_ufl = 1'b0;
  logic        b_ufl_a = 1'b0;
  cia::tctrl_t b_ctrl;
  logic        b_pbon;
  cia::reg8_t  b_regs;

  typedef struct {
    int         due;
    string      tag;
    int         sel;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses_a = 0;
  int   snap;

  cia_timer_ctrl #(.TIMER_B(0)) dut_a (
    .clk     (clk),
    .res     (res),
    .phi2_dn (phi2_dn),
    .cr_w    (a_cr_w),
    .data    (a_data),
    .cnt     (cnt),
    .ufl_a   (a_ufl_a),
    .ufl     (a_ufl),
    .ctrl    (a_ctrl),
    .pbon    (a_pbon),
    .regs    (a_regs)
  );

  cia_timer_ctrl #(.TIMER_B(1)) dut_b (
    .clk     (clk),
    .res     (res),
    .phi2_dn (phi2_dn),
    .cr_w    (b_cr_w),
    .data    (b_data),
    .cnt     (cnt),
    .ufl_a   (b_ufl_a),
    .ufl     (b_ufl),
    .ctrl    (b_ctrl),
    .pbon    (b_pbon),
    .regs    (b_regs)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_ctrl.count) pulses_a++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      CTRL_A:  return {4'h0, a_ctrl};
      REGS_A:  return a_regs;
      PBON_A:  return {7'h00, a_pbon};
      CTRL_B:  return {4'h0, b_ctrl};
      REGS_B:  return b_regs;
      default: return {7'h00, b_pbon};
    endcase
  endfunction

  task automatic expect_at(input int after, input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.due = cyc + after;
    e.tag = tag;
    e.sel = sel;
    e.v   = v;
    sb.push_back(e);
  endtask

  // One clock edge; outputs are sampled 1 time unit later and due expectations popped.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(e.sel), e.v);
    end
  endtask

  // ctrl packing: {start, toggle, count, force_load}
  function automatic logic [7:0] cv(input logic s, input logic t, input logic c, input logic f);
    return {4'h0, s, t, c, f};
  endfunction

  initial begin
    #2;
    check_eq("rst_ctrl_a", obs(CTRL_A), 8'h00);
    check_eq("rst_regs_a", obs(REGS_A), 8'h00);
    check_eq("rst_pbon_a", obs(PBON_A), 8'h00);
    check_eq("rst_ctrl_b", obs(CTRL_B), 8'h00);
    check_eq("rst_regs_b", obs(REGS_B), 8'h00);
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    tick();

    // Continuous mode
    a_cr_w = 1'b1; a_data = 8'h01;
    expect_at(1, "cont_ctrl", CTRL_A, cv(1, 0, 1, 0));
    expect_at(1, "cont_regs", REGS_A, 8'h01);
    tick();
    a_cr_w = 1'b0;
    expect_at(1, "cont_hold", CTRL_A, cv(1, 0, 1, 0));
    tick();

    // One-shot stop on underflow
    a_cr_w = 1'b1; a_data = 8'h09;
    expect_at(1, "os_run_ctrl", CTRL_A, cv(1, 0, 1, 0));
    expect_at(1, "os_run_regs", REGS_A, 8'h09);
    tick();
    a_cr_w = 1'b0; a_ufl = 1'b1;
    expect_at(1, "os_stop_ctrl", CTRL_A, cv(0, 0, 0, 0));
    expect_at(1, "os_stop_regs", REGS_A, 8'h08);
    tick();
    a_ufl = 1'b0;
    expect_at(1, "os_after_ctrl", CTRL_A, cv(0, 0, 0, 0));
    tick();

    // Write and one-shot underflow in the same cycle: written START wins
    a_cr_w = 1'b1; a_data = 8'h09; a_ufl = 1'b1;
    expect_at(1, "coll_ctrl", CTRL_A, cv(1, 0, 1, 0));
    expect_at(1, "coll_regs", REGS_A, 8'h09);
    tick();
    a_cr_w = 1'b0; a_ufl = 1'b0;
    tick();

    // Force load strobe, LOAD bit not stored
    a_cr_w = 1'b1; a_data = 8'h10;
    expect_at(1, "fl_ctrl", CTRL_A, cv(0, 0, 0, 1));
    expect_at(1, "fl_regs", REGS_A, 8'h00);
    tick();
    a_cr_w = 1'b0;
    expect_at(1, "fl_clear", CTRL_A, cv(0, 0, 0, 0));
    tick();

    // No update while phi2_dn is low, then PBON/OUTMODE write
    phi2_dn = 1'b0; a_cr_w = 1'b1; a_data = 8'h07;
    expect_at(1, "gate_ctrl", CTRL_A, cv(0, 0, 0, 0));
    expect_at(1, "gate_regs", REGS_A, 8'h00);
    tick();
    phi2_dn = 1'b1; a_data = 8'h06;
    expect_at(1, "pb_ctrl", CTRL_A, cv(0, 1, 0, 0));
    expect_at(1, "pb_regs", REGS_A, 8'h06);
    expect_at(1, "pb_pbon", PBON_A, 8'h01);
    tick();
    a_cr_w = 1'b0;

    // CNT mode on timer A
    cnt = 1'b0;
    tick();
    a_cr_w = 1'b1; a_data = 8'h21;
    expect_at(1, "cnt_ctrl", CTRL_A, cv(1, 0, 0, 0));
    expect_at(1, "cnt_regs", REGS_A, 8'h21);
    tick();
    a_cr_w = 1'b0;
    snap = pulses_a;
    for (int i = 0; i < 3; i++) begin
      cnt = 1'b1;
      expect_at(1, "cnt_rise", CTRL_A, cv(1, 0, CE, 0));
      tick();
      expect_at(1, "cnt_high", CTRL_A, cv(1, 0, 0, 0));
      tick();
      cnt = 1'b0;
      expect_at(1, "cnt_low", CTRL_A, cv(1, 0, 0, 0));
      tick();
    end
    check_eq("cnt_pulses", pulses_a - snap, CE ? 3 : 0);
    a_cr_w = 1'b1; a_data = 8'h00;
    tick();
    a_cr_w = 1'b0;

    // Timer B input modes
    b_cr_w = 1'b1; b_data = 8'h01;
    expect_at(1, "b_m00_ctrl", CTRL_B, cv(1, 0, 1, 0));
    expect_at(1, "b_m00_regs", REGS_B, 8'h01);
    tick();
    b_data = 8'h41;
    expect_at(1, "b_m10_idle", CTRL_B, cv(1, 0, 0, 0));
    expect_at(1, "b_m10_regs", REGS_B, 8'h41);
    tick();
    b_cr_w = 1'b0; b_ufl_a = 1'b1;
    expect_at(1, "b_m10_ufla", CTRL_B, cv(1, 0, 1, 0));
    tick();
    b_ufl_a = 1'b0;
    expect_at(1, "b_m10_off", CTRL_B, cv(1, 0, 0, 0));
    tick();
    b_cr_w = 1'b1; b_data = 8'h61;
    expect_at(1, "b_m11_ctrl", CTRL_B, cv(1, 0, 0, 0));
    expect_at(1, "b_m11_regs", REGS_B, 8'h61);
    tick();
    b_cr_w = 1'b0; b_ufl_a = 1'b1; cnt = 1'b0;
    expect_at(1, "b_m11_cnt0", CTRL_B, cv(1, 0, 0, 0));
    tick();
    b_ufl_a = 1'b0;
    expect_at(1, "b_m11_gap", CTRL_B, cv(1, 0, 0, 0));
    tick();
    b_ufl_a = 1'b1; cnt = 1'b1;
    a_cr_w = 1'b1; a_data = 8'h10;
    expect_at(1, "b_m11_cnt1", CTRL_B, cv(1, 0, CE, 0));
    expect_at(1, "pre_rst_fl", CTRL_A, cv(0, 0, 0, 1));
    tick();

    // Asynchronous reset mid-sequence
    #2;
    res = 1'b1;
    #1;
    check_eq("arst_ctrl_a", obs(CTRL_A), 8'h00);
    check_eq("arst_regs_a", obs(REGS_A), 8'h00);
    check_eq("arst_pbon_a", obs(PBON_A), 8'h00);
    check_eq("arst_ctrl_b", obs(CTRL_B), 8'h00);
    check_eq("arst_regs_b", obs(REGS_B), 8'h00);
    check_eq("arst_pbon_b", obs(PBON_B), 8'h00);
    a_cr_w = 1'b0; b_ufl_a = 1'b0;
    #2;
    res = 1'b0;
    expect_at(1, "post_rst_a", CTRL_A, cv(0, 0, 0, 0));
    expect_at(1, "post_rst_b", CTRL_B, cv(0, 0, 0, 0));
    tick();
    tick();

    check_eq("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
